multiport_rf_sb: RTL and testbench
==================================

Name: multiport_rf_sb

Overview:
Parametrised multi-port integer register file with an integrated scoreboard, for the multi-issue core pipeline.
- Generalises the fixed 2-write/4-read file to configurable data width, register count and port counts.
- Adds asynchronous reset of all registers, optional same-cycle write-to-read bypass, and per-register busy bits for issue-stage hazard checking.
- Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

Parameters:
XLEN, 64, data width in bits
NREG, 32, number of architectural registers; power of two, at least 2; AW = clog2(NREG) is derived, not overridable
NRD, 4, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = read data and busy reflect same-cycle writes; 0 = reads see registered state only

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
rd_data  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
rd_busy  out  NRD  busy flag of each read address
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
sb_set_en  in  NWR  scoreboard set enables (one per issue slot)
sb_set_addr  in  NWR*AW  destination register being issued
flush  in  1  clear every busy bit
busy_vec  out  NREG  full scoreboard state, registered

Behaviour:
- Reset (asynchronous, active-high): all NREG registers become 0 and all busy bits become 0 immediately. Consequences:
  - rd_data = 0 on every port.
  - rd_busy = 0 and busy_vec = 0.
  - State holds while reset is high.
  - Any write or set present during reset is discarded.
  - Release takes effect at the next rising clock edge.
- Register 0 (x0):
  - Always reads 0 and never becomes busy.
  - Writes to it and sb_set_en targeting it are ignored.
  - busy_vec[0] is constantly 0.
- Writes: on a rising edge, reg[wr_addr[j]] <= wr_data[j] for every j with wr_en[j] = 1.
- Write conflict: when several enabled ports target the same address, the highest-index port wins.
- Reads are combinational from the register array, with zero cycles of latency.
- BYPASS = 1:
  - If any enabled write port targets a nonzero rd_addr[i] in the current cycle, rd_data[i] takes that write's data.
  - The highest-index matching port wins, consistent with commit priority.
- BYPASS = 0: rd_data[i] shows the pre-edge register value; the new value is visible the cycle after the write.
- Scoreboard update per nonzero register r, at the rising edge, highest priority first:
  1. Set: any sb_set_en[j] with sb_set_addr[j] = r gives busy[r] <= 1. Set wins over a clear in the same cycle because it is a new producer.
  2. Flush: flush = 1 gives busy[r] <= 0. Flush overrides writeback clears but not a same-cycle set.
  3. Clear: any wr_en[j] with wr_addr[j] = r gives busy[r] <= 0.
  4. Otherwise busy[r] holds.
- rd_busy[i]:
  - BYPASS = 0: busy[rd_addr[i]].
  - BYPASS = 1: busy[rd_addr[i]] AND NOT (a same-cycle write to rd_addr[i]).
  - rd_addr[i] = 0 always gives 0.
  - Same-cycle sets never affect rd_busy; they are visible from the next cycle.
- Duplicate sets to the same register are idempotent.
- A write to a non-busy register is legal: data is updated and busy stays 0.
- No internal state other than the register array and busy bits; no stalls and no handshake.

Test Plan:
1. Reset mid-operation:
   - Write x5 = 0xDEAD, set busy x7, then assert reset between clock edges.
   - Expect rd_data for x5 = 0 immediately, busy_vec = 0, and rd_data stays 0 after release.
2. x0 handling:
   - wr_en[0] = 1, wr_addr = 0, data 0xFFFF; sb_set to x0.
   - Expect reading x0 returns 0 on all NRD ports and busy_vec[0] = 0.
3. Write conflict:
   - Port 0 writes x3 = 0x11 and port 1 writes x3 = 0x22 in the same cycle.
   - Expect x3 reads 0x22 next cycle.
   - With BYPASS = 1, expect a same-cycle read of x3 to show 0x22.
4. Bypass:
   - x9 holds 0xA; write x9 = 0xB while reading x9.
   - BYPASS = 1: rd_data = 0xB in the same cycle.
   - BYPASS = 0: rd_data = 0xA, then 0xB the next cycle.
5. Scoreboard priority:
   - In one cycle, sb_set x4 and write x4 -> busy[4] = 1.
   - Next cycle, write x4 only -> busy[4] = 0.
   - In one cycle, flush plus sb_set x6 -> busy[6] = 1, all other bits 0.
6. rd_busy timing:
   - x8 busy; write x8 while reading it.
   - BYPASS = 1: rd_busy = 0 in the same cycle.
   - BYPASS = 0: rd_busy = 1, then 0 the next cycle.
   - Set x10 while reading x10: rd_busy = 0 in the set cycle, 1 the next cycle.

Source files
------------

// File: rtl/multiport_rf_sb_if.sv
// Bus bundle for the multi-port register file / scoreboard.
// master: issue/writeback side driving requests; slave: the register file.
interface multiport_rf_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 4,
  parameter int unsigned NWR  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      sb_set_en;
  logic [NWR*AW-1:0]   sb_set_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/multiport_rf_sb.sv
// Parametrised multi-port integer register file with per-register busy bits.
// Reads are combinational (optionally bypassing same-cycle writes); writes and
// scoreboard updates commit on the rising clock edge. x0 is hardwired to zero.
module multiport_rf_sb #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 4,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  multiport_rf_sb_if.slave rf
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic [AW-1:0]       rd_sel [NRD];
  logic [NRD-1:0]      rd_hit;
  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]      rd_busy_c;

  // Register commit: ascending port order so the highest-index port wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (rf.wr_en[j]) begin
        regs_d[rf.wr_addr[j*AW +: AW]] = rf.wr_data[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Scoreboard next state: clear, then flush, then set, so later steps override.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (rf.wr_en[j]) begin
        busy_d[rf.wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rf.flush) begin
      busy_d = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (rf.sb_set_en[j]) begin
        busy_d[rf.sb_set_addr[j*AW +: AW]] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear; inputs are ignored while in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: array lookup, optional write bypass, x0 forced to zero/not busy.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    rd_hit    = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_sel[i] = rf.rd_addr[i*AW +: AW];
      rd_data_c[i*XLEN +: XLEN] = regs_q[rd_sel[i]];
      // Bypass is suppressed in reset so outputs read as zero until release.
      if (BYPASS && !reset) begin
        for (int j = 0; j < NWR; j++) begin
          if (rf.wr_en[j] && (rf.wr_addr[j*AW +: AW] == rd_sel[i])) begin
            rd_data_c[i*XLEN +: XLEN] = rf.wr_data[j*XLEN +: XLEN];
            rd_hit[i] = 1'b1;
          end
        end
      end
      rd_busy_c[i] = busy_q[rd_sel[i]] & ~rd_hit[i];
      if (rd_sel[i] == '0) begin
        rd_data_c[i*XLEN +: XLEN] = '0;
        rd_busy_c[i] = 1'b0;
      end
    end
  end

  assign rf.rd_data  = rd_data_c;
  assign rf.rd_busy  = rd_busy_c;
  assign rf.busy_vec = busy_q;

endmodule

// File: tb/tb_multiport_rf_sb.sv
// Bench for multiport_rf_sb: one instance with bypass, one without, driven by
// the same directed stimulus and checked every cycle against a behavioural model.
module tb_multiport_rf_sb;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 4;
  localparam int unsigned NWR  = 2;
  localparam int unsigned AW   = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Stimulus in unpacked form, packed onto both interfaces.
  logic [AW-1:0]   ra [NRD];
  logic            we [NWR];
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic            se [NWR];
  logic [AW-1:0]   sa [NWR];
  logic            fl;

  logic [NRD*AW-1:0]   rd_addr_p;
  logic [NWR-1:0]      wr_en_p;
  logic [NWR*AW-1:0]   wr_addr_p;
  logic [NWR*XLEN-1:0] wr_data_p;
  logic [NWR-1:0]      sb_set_en_p;
  logic [NWR*AW-1:0]   sb_set_addr_p;

  always_comb begin
    rd_addr_p = '0; wr_en_p = '0; wr_addr_p = '0; wr_data_p = '0;
    sb_set_en_p = '0; sb_set_addr_p = '0;
    for (int i = 0; i < NRD; i++) rd_addr_p[i*AW +: AW] = ra[i];
    for (int j = 0; j < NWR; j++) begin
      wr_en_p[j] = we[j];
      wr_addr_p[j*AW +: AW] = wa[j];
      wr_data_p[j*XLEN +: XLEN] = wd[j];
      sb_set_en_p[j] = se[j];
      sb_set_addr_p[j*AW +: AW] = sa[j];
    end
  end

  multiport_rf_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) if_b1 ();
  multiport_rf_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) if_b0 ();

  assign if_b1.rd_addr = rd_addr_p;     assign if_b0.rd_addr = rd_addr_p;
  assign if_b1.wr_en = wr_en_p;         assign if_b0.wr_en = wr_en_p;
  assign if_b1.wr_addr = wr_addr_p;     assign if_b0.wr_addr = wr_addr_p;
  assign if_b1.wr_data = wr_data_p;     assign if_b0.wr_data = wr_data_p;
  assign if_b1.sb_set_en = sb_set_en_p; assign if_b0.sb_set_en = sb_set_en_p;
  assign if_b1.sb_set_addr = sb_set_addr_p;
  assign if_b0.sb_set_addr = sb_set_addr_p;
  assign if_b1.flush = fl;              assign if_b0.flush = fl;

  multiport_rf_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)
  ) u_dut_b1 (
    .clock (clock),
    .reset (reset),
    .rf    (if_b1)
  );

  multiport_rf_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)
  ) u_dut_b0 (
    .clock (clock),
    .reset (reset),
    .rf    (if_b0)
  );

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_reg [NREG];
  logic            m_busy [NREG];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        bit is_set, is_wr;
        is_set = 0; is_wr = 0;
        for (int j = 0; j < NWR; j++) begin
          if (se[j] && sa[j] == r) is_set = 1;
          if (we[j] && wa[j] == r) is_wr = 1;
        end
        // Commit data: the last (highest-index) matching port is the one kept.
        for (int j = NWR - 1; j >= 0; j--) begin
          if (we[j] && wa[j] == r) begin m_reg[r] = wd[j]; break; end
        end
        if (is_set) m_busy[r] = 1'b1;
        else if (fl || is_wr) m_busy[r] = 1'b0;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(int i, bit byp);
    logic [XLEN-1:0] v;
    if (ra[i] == 0) return '0;
    v = m_reg[ra[i]];
    if (byp && !reset)
      for (int j = 0; j < NWR; j++) if (we[j] && wa[j] == ra[i]) v = wd[j];
    return v;
  endfunction

  function automatic logic exp_busy(int i, bit byp);
    bit hit;
    if (ra[i] == 0) return 1'b0;
    hit = 0;
    for (int j = 0; j < NWR; j++) if (we[j] && wa[j] == ra[i]) hit = 1;
    return m_busy[ra[i]] && !(byp && hit);
  endfunction

  function automatic logic [NREG-1:0] exp_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic logic [XLEN-1:0] rd1(int i); return if_b1.rd_data[i*XLEN +: XLEN];
  endfunction
  function automatic logic [XLEN-1:0] rd0(int i); return if_b0.rd_data[i*XLEN +: XLEN];
  endfunction

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("cyc rd_data b1 p%0d", i), rd1(i), exp_rd(i, 1'b1));
        check($sformatf("cyc rd_data b0 p%0d", i), rd0(i), exp_rd(i, 1'b0));
        check($sformatf("cyc rd_busy b1 p%0d", i), 64'(if_b1.rd_busy[i]), 64'(exp_busy(i, 1'b1)));
        check($sformatf("cyc rd_busy b0 p%0d", i), 64'(if_b0.rd_busy[i]), 64'(exp_busy(i, 1'b0)));
      end
      check("cyc busy_vec b1", 64'(if_b1.busy_vec), 64'(exp_vec()));
      check("cyc busy_vec b0", 64'(if_b0.busy_vec), 64'(exp_vec()));
    end
  end

  task automatic idle();
    for (int i = 0; i < NRD; i++) ra[i] = '0;
    for (int j = 0; j < NWR; j++) begin
      we[j] = 0; wa[j] = '0; wd[j] = '0; se[j] = 0; sa[j] = '0;
    end
    fl = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    tick(); tick();
    reset = 1'b0;
    chk_en = 1;
    #1;
    check("reset busy_vec", 64'(if_b1.busy_vec), 64'h0);
    check("reset rd_data", rd0(0), 64'h0);

    // 1. reset mid-operation, with a write presented during reset
    we[0] = 1; wa[0] = 5; wd[0] = 64'hDEAD; se[0] = 1; sa[0] = 7;
    tick(); idle(); ra[0] = 5; ra[1] = 7;
    #1;
    check("t1 x5 b1", rd1(0), 64'hDEAD);
    check("t1 x5 b0", rd0(0), 64'hDEAD);
    check("t1 busy x7", 64'(if_b0.rd_busy[1]), 64'h1);
    check("t1 busy_vec", 64'(if_b0.busy_vec), 64'h80);
    #1;
    reset = 1'b1; we[0] = 1; wa[0] = 5; wd[0] = 64'hBEEF;
    #1;
    check("t1 in-reset x5 b1", rd1(0), 64'h0);
    check("t1 in-reset x5 b0", rd0(0), 64'h0);
    check("t1 in-reset busy_vec", 64'(if_b1.busy_vec), 64'h0);
    tick(); reset = 1'b0; idle(); ra[0] = 5;
    #1;
    check("t1 after release x5", rd1(0), 64'h0);

    // 2. x0 handling
    tick(); idle();
    we[0] = 1; wa[0] = 0; wd[0] = 64'hFFFF; se[0] = 1; sa[0] = 0;
    #1;
    check("t2 same-cycle x0 b1", rd1(0), 64'h0);
    tick(); idle();
    #1;
    for (int i = 0; i < NRD; i++) check($sformatf("t2 x0 p%0d", i), rd1(i), 64'h0);
    check("t2 busy_vec0", 64'(if_b1.busy_vec[0]), 64'h0);

    // 3. write conflict
    we[0] = 1; wa[0] = 3; wd[0] = 64'h11; we[1] = 1; wa[1] = 3; wd[1] = 64'h22; ra[0] = 3;
    #1;
    check("t3 same-cycle b1", rd1(0), 64'h22);
    check("t3 same-cycle b0", rd0(0), 64'h0);
    tick(); idle(); ra[0] = 3;
    #1;
    check("t3 next b1", rd1(0), 64'h22);
    check("t3 next b0", rd0(0), 64'h22);

    // 4. bypass
    tick(); idle(); we[0] = 1; wa[0] = 9; wd[0] = 64'hA;
    tick(); idle(); we[1] = 1; wa[1] = 9; wd[1] = 64'hB; ra[0] = 9;
    #1;
    check("t4 bypass b1", rd1(0), 64'hB);
    check("t4 no-bypass b0", rd0(0), 64'hA);
    tick(); idle(); ra[0] = 9;
    #1;
    check("t4 next b0", rd0(0), 64'hB);

    // 5. scoreboard priority
    tick(); idle(); se[0] = 1; sa[0] = 4; we[1] = 1; wa[1] = 4; wd[1] = 64'h44;
    tick(); idle();
    #1;
    check("t5 set beats clear", 64'(if_b1.busy_vec), 64'h10);
    we[0] = 1; wa[0] = 4; wd[0] = 64'h45;
    tick(); idle();
    #1;
    check("t5 clear", 64'(if_b1.busy_vec), 64'h0);
    se[0] = 1; sa[0] = 6; se[1] = 1; sa[1] = 12;
    tick(); idle(); fl = 1; se[0] = 1; sa[0] = 6;
    tick(); idle();
    #1;
    check("t5 flush+set", 64'(if_b0.busy_vec), 64'h40);

    // 6. rd_busy timing
    se[0] = 1; sa[0] = 8;
    tick(); idle(); we[0] = 1; wa[0] = 8; wd[0] = 64'h88; ra[0] = 8;
    #1;
    check("t6 wr busy b1", 64'(if_b1.rd_busy[0]), 64'h0);
    check("t6 wr busy b0", 64'(if_b0.rd_busy[0]), 64'h1);
    tick(); idle(); ra[0] = 8;
    #1;
    check("t6 after wr b0", 64'(if_b0.rd_busy[0]), 64'h0);
    se[1] = 1; sa[1] = 10; ra[1] = 10;
    #1;
    check("t6 set-cycle b1", 64'(if_b1.rd_busy[1]), 64'h0);
    check("t6 set-cycle b0", 64'(if_b0.rd_busy[1]), 64'h0);
    tick(); idle(); ra[1] = 10;
    #1;
    check("t6 next b1", 64'(if_b1.rd_busy[1]), 64'h1);
    check("t6 next b0", 64'(if_b0.rd_busy[1]), 64'h1);

    // Mixed traffic, checked only by the per-cycle model comparison.
    for (int k = 0; k < 24; k++) begin
      tick(); idle();
      we[0] = 1; wa[0] = AW'((k * 7 + 3) % NREG); wd[0] = 64'(k) * 64'h0101_0101 + 64'h1;
      we[1] = (k % 3) != 0; wa[1] = AW'((k * 5 + 1) % NREG); wd[1] = ~wd[0];
      se[0] = (k % 2) != 0; sa[0] = AW'((k * 11) % NREG);
      se[1] = (k % 4) == 0; sa[1] = AW'((k * 13 + 2) % NREG);
      fl = (k % 9) == 8;
      for (int i = 0; i < NRD - 1; i++) ra[i] = AW'((k + i * 9) % NREG);
      ra[NRD-1] = wa[1];
    end
    tick(); idle();
    tick(); tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
